// File: rtl/reg_dump_sequencer.sv
// Streams a header byte then every register MSB-first to a byte transmitter.
// Latency: header offered one cycle after start; one LOAD bubble per register.
// Backpressure: txValid/txData hold while txReady=0; abort drops to IDLE next edge.
module reg_dump_sequencer #(
    parameter int unsigned NUM_REGS = 32,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy,
    output logic        pipeEnable,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, DONE} state_t;

    localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

    state_t      state_q;
    logic [31:0] shift_q;
    logic [1:0]  byte_cnt_q;
    logic [4:0]  addr_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;

    // The header is parked in the top byte of the shift register so txData
    // is always shift_q[31:24] and every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort && state_q != IDLE) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= HDR;
                        shift_q    <= {HEADER, 24'h000000};
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                HDR: begin
                    if (tx_valid_q && txReady) begin
                        addr_q     <= '0;
                        tx_valid_q <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q    <= regData;
                    byte_cnt_q <= '0;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (tx_valid_q && txReady) begin
                        if (byte_cnt_q != 2'd3) begin
                            shift_q    <= {shift_q[23:0], 8'h00};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end else if (addr_q < LAST_ADDR) begin
                            addr_q     <= addr_q + 5'd1;
                            tx_valid_q <= 1'b0;
                            state_q    <= LOAD;
                        end else begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign regAddr    = addr_q;
    assign txData     = shift_q[31:24];
    assign txValid    = tx_valid_q;
    assign busy       = busy_q;
    assign pipeEnable = ~busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: a 32-register instance checked against a byte-queue
// model, plus a single-register instance checked against literal bytes.
module tb_reg_dump_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        startA, abortA, txReadyA;
    logic [4:0]  regAddrA;
    logic [31:0] regDataA;
    logic [7:0]  txDataA;
    logic        txValidA, busyA, pipeEnableA, doneA;

    logic        startB;
    logic [4:0]  regAddrB;
    logic [31:0] regDataB;
    logic [7:0]  txDataB;
    logic        txValidB, busyB, pipeEnableB, doneB;

    logic [31:0] regsA [32];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_log[$];
    logic [7:0]  rxB[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          doneB_cnt = 0;
    int          addrB_bad = 0;
    logic        rand_mode = 1'b0;
    logic        ready_level = 1'b1;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always #5 clk = ~clk;

    assign regDataA = regsA[regAddrA];
    assign regDataB = (regAddrB == 5'd0) ? 32'hDEADBEEF : 32'h00000000;

    reg_dump_sequencer dutA (
        .clk(clk), .reset(reset), .start(startA), .abort(abortA),
        .regAddr(regAddrA), .regData(regDataA), .txData(txDataA),
        .txValid(txValidA), .txReady(txReadyA), .busy(busyA),
        .pipeEnable(pipeEnableA), .done(doneA)
    );

    reg_dump_sequencer #(.NUM_REGS(1), .HEADER(8'hA5)) dutB (
        .clk(clk), .reset(reset), .start(startB), .abort(1'b0),
        .regAddr(regAddrB), .regData(regDataB), .txData(txDataB),
        .txValid(txValidB), .txReady(1'b1), .busy(busyB),
        .pipeEnable(pipeEnableB), .done(doneB)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        txReadyA = rand_mode ? ($urandom_range(0, 9) < 3) : ready_level;
    end

    // Compare process for instance A: every accepted byte is popped from the model.
    always @(negedge clk) begin
        chk("pipe_en_a", pipeEnableA, !busyA);
        if (prev_stall) begin
            chk("hold_valid", txValidA, 1'b1);
            chk("hold_data", txDataA, prev_data);
        end
        if (txValidA && txReadyA) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_byte: got 0x%0h want no byte", txDataA);
            end else begin
                chk("byte", txDataA, exp_q.pop_front());
            end
            rx_log.push_back(txDataA);
        end
        if (doneA) begin
            done_cnt++;
            chk("done_all_sent", exp_q.size(), 0);
            chk("done_valid_low", txValidA, 1'b0);
        end
        prev_stall = txValidA && !txReadyA && !abortA && reset;
        prev_data  = txDataA;
    end

    always @(negedge clk) begin
        chk("pipe_en_b", pipeEnableB, !busyB);
        if (txValidB) rxB.push_back(txDataB);
        if (doneB) doneB_cnt++;
        if (regAddrB != 5'd0) addrB_bad++;
    end

    task automatic build_exp();
        exp_q.delete();
        rx_log.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 32; i++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(regsA[i][8*b +: 8]);
    endtask

    task automatic pulse_start();
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string nm);
        int   n;
        logic pe_seen;
        n = 0;
        pe_seen = 1'b0;
        while (done_cnt == prev && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (done_cnt == prev && pipeEnableA) pe_seen = 1'b1;
        end
        chk({nm, "_done"}, done_cnt, prev + 1);
        chk({nm, "_pe_low"}, pe_seen, 1'b0);
    endtask

    task automatic wait_bytes(input int cnt, input string nm);
        int n;
        n = 0;
        while (rx_log.size() < cnt && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_reach"}, rx_log.size(), cnt);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_addr"}, regAddrA, 5'd0);
        chk({nm, "_data"}, txDataA, 8'h00);
        chk({nm, "_valid"}, txValidA, 1'b0);
        chk({nm, "_busy"}, busyA, 1'b0);
        chk({nm, "_pe"}, pipeEnableA, 1'b1);
        chk({nm, "_done"}, doneA, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          prev;
        logic [7:0]  wantB [5];
        for (int i = 0; i < 32; i++) regsA[i] = 32'h01000000 + i;
        reset  = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        abortA = 1'b0;
        #2;
        chk_reset_outputs("por");
        #20 reset = 1'b1;
        @(posedge clk); #1;

        // Full frame with txReady held high.
        build_exp();
        chk("model_len", exp_q.size(), 129);
        chk("model_last", exp_q[128], 8'h1F);
        prev = done_cnt;
        pulse_start();
        wait_done(prev, "t1");
        chk("t1_len", rx_log.size(), 129);
        chk("t1_b0", rx_log[0], 8'hA5);
        chk("t1_b1", rx_log[1], 8'h01);
        chk("t1_b8", rx_log[8], 8'h01);
        chk("t1_b127", rx_log[127], 8'h00);
        chk("t1_b128", rx_log[128], 8'h1F);

        // 30% txReady duty with extra start pulses that must be ignored.
        repeat (3) @(posedge clk);
        #1;
        rand_mode = 1'b1;
        build_exp();
        prev = done_cnt;
        pulse_start();
        repeat (40) @(posedge clk);
        #1;
        pulse_start();
        repeat (100) @(posedge clk);
        #1;
        pulse_start();
        wait_done(prev, "t2");
        rand_mode = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t2_one_done", done_cnt, prev + 1);
        chk("t2_len", rx_log.size(), 129);

        // Abort while byte 2 of register 5 (frame byte 22) is on offer.
        build_exp();
        prev = done_cnt;
        pulse_start();
        wait_bytes(22, "t3");
        chk("t3_offer_valid", txValidA, 1'b1);
        abortA = 1'b1;
        @(posedge clk); #1;
        abortA = 1'b0;
        exp_q.delete();
        chk("t3_busy", busyA, 1'b0);
        chk("t3_pe", pipeEnableA, 1'b1);
        chk("t3_valid", txValidA, 1'b0);
        chk("t3_sent", rx_log.size(), 23);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_no_done", done_cnt, prev);
        chk("t3_no_more", rx_log.size(), 23);
        build_exp();
        prev = done_cnt;
        pulse_start();
        wait_done(prev, "t3r");
        chk("t3r_len", rx_log.size(), 129);
        chk("t3r_b0", rx_log[0], 8'hA5);

        // Asynchronous reset mid-SEND, then silence until a new start.
        build_exp();
        prev = done_cnt;
        pulse_start();
        wait_bytes(10, "t4");
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("t4");
        exp_q.delete();
        #2 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_silent", rx_log.size(), 10);
        chk("t4_idle", busyA, 1'b0);
        chk("t4_no_done", done_cnt, prev);
        build_exp();
        pulse_start();
        wait_done(prev, "t4r");
        chk("t4r_len", rx_log.size(), 129);

        // Single-register instance.
        rxB.delete();
        doneB_cnt = 0;
        addrB_bad = 0;
        wantB[0] = 8'hA5;
        wantB[1] = 8'hDE;
        wantB[2] = 8'hAD;
        wantB[3] = 8'hBE;
        wantB[4] = 8'hEF;
        startB = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        for (int n = 0; n < 100 && doneB_cnt == 0; n++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("b_done", doneB_cnt, 1);
        chk("b_len", rxB.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("b_byte", (i < rxB.size()) ? rxB[i] : 8'hXX, wantB[i]);
        chk("b_addr_zero", addrB_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
